// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied in the top level.
package seg_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Entry n is the glyph for hex digit n (entry 0 in the least significant slot).
    localparam logic [15:0][6:0] GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display data/control bundle between the channel mux (master) and the scan controller (slave).
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 8
);
    logic                  en;
    logic                  load;
    logic                  mode;
    logic [4*DIGITS-1:0]   data;
    logic [8*DIGITS-1:0]   raw_seg;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic [DIGITS-1:0]     blink;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  pending;
    logic                  frame;

    modport master (
        output en, load, mode, data, raw_seg, dp, blank, blink,
        input  seg, an, pending, frame
    );

    modport slave (
        input  en, load, mode, data, raw_seg, dp, blank, blink,
        output seg, an, pending, frame
    );
endinterface

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-high seven-segment glyph.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = GLYPH[nibble];
endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit seven-segment scan controller with double buffering, guard gap and blink.
// Define SEG_LZB_EN to enable leading-zero blanking in hex mode.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SCAN_DIV_W  = 17,
    parameter int BLINK_DIV_W = 25,
    parameter int GUARD_CYC   = 16,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_ctrl_if.slave   bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SCAN_DIV_W-1:0] GUARD_END = SCAN_DIV_W'(GUARD_CYC - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [7:0]            SEG_IDLE  = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0]     AN_IDLE   = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef struct packed {
        logic                mode;
        logic [4*DIGITS-1:0] data;
        logic [8*DIGITS-1:0] raw;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blank;
        logic [DIGITS-1:0]   blink;
    } img_t;

    scan_state_e              state_q, state_d;
    logic [SCAN_DIV_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [BLINK_DIV_W-1:0]   blink_q, blink_d;
    img_t                     pend_buf_q, pend_buf_d;
    img_t                     act_buf_q, act_buf_d;
    logic                     pending_q, pending_d;
    logic                     frame_q, frame_d;
    logic [7:0]               seg_q, seg_d;
    logic [DIGITS-1:0]        an_q, an_d;
    logic                     wrap;
    logic [3:0]               cur_nibble;
    logic [6:0]               glyph7;
    logic                     lz_dark;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + SCAN_DIV_W'(1);
        blink_d = blink_q + BLINK_DIV_W'(1);
        wrap    = 1'b0;
        case (state_q)
            GUARD: if (cnt_q == GUARD_END) state_d = DRIVE;
            DRIVE: if (&cnt_q) begin
                state_d = GUARD;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = GUARD;
        endcase
    end

    // Pending image is promoted only at the frame wrap so a frame never mixes two images.
    always_comb begin
        pend_buf_d = pend_buf_q;
        if (bus.load) begin
            pend_buf_d = '{mode: bus.mode, data: bus.data, raw: bus.raw_seg,
                           dp: bus.dp, blank: bus.blank, blink: bus.blink};
        end
        act_buf_d = (wrap && pending_q) ? pend_buf_q : act_buf_q;
        pending_d = bus.load | (pending_q & ~wrap);
        frame_d   = wrap;
    end

    always_comb cur_nibble = act_buf_q.data[4*int'(idx_q) +: 4];

    hex7seg u_hex7seg (
        .nibble (cur_nibble),
        .seg    (glyph7)
    );

`ifdef SEG_LZB_EN
    int hi_nz;
    always_comb begin
        hi_nz = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (act_buf_q.data[4*i +: 4] != 4'h0) hi_nz = i;
        end
        lz_dark = !act_buf_q.mode && (int'(idx_q) > hi_nz);
    end
`else
    always_comb lz_dark = 1'b0;
`endif

    always_comb begin
        logic       lit;
        logic       dark;
        logic [7:0] seg_on;
        logic [DIGITS-1:0] an_on;
        dark   = act_buf_q.blank[idx_q] | (act_buf_q.blink[idx_q] & blink_q[BLINK_DIV_W-1]) | lz_dark;
        lit    = bus.en && (state_q == DRIVE) && !dark;
        seg_on = SEG_OFF;
        an_on  = '0;
        if (lit) begin
            seg_on = act_buf_q.mode ? act_buf_q.raw[8*int'(idx_q) +: 8]
                                    : {act_buf_q.dp[idx_q], glyph7};
            an_on  = DIGITS'(1) << idx_q;
        end
        seg_d = (ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        an_d  = (ACTIVE_LOW != 0) ? ~an_on : an_on;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GUARD;
            cnt_q      <= '0;
            idx_q      <= '0;
            blink_q    <= '0;
            pend_buf_q <= '0;
            act_buf_q  <= '0;
            pending_q  <= 1'b0;
            frame_q    <= 1'b0;
            seg_q      <= SEG_IDLE;
            an_q       <= AN_IDLE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            blink_q    <= blink_d;
            pend_buf_q <= pend_buf_d;
            act_buf_q  <= act_buf_d;
            pending_q  <= pending_d;
            frame_q    <= frame_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.pending = pending_q;
    assign bus.frame   = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, short dwell/blink) against a cycle-count model.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int D     = 4;
    localparam int SW    = 4;
    localparam int BW    = 6;
    localparam int GC    = 2;
    localparam int AL    = 1;
    localparam int DWELL = 2**SW;
    localparam int FRAME = DWELL * D;
    localparam int BLINK = 2**BW;

    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic [31:0] raw;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
    } img_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.DIGITS(D)) bus ();

    seg_scan_ctrl #(
        .DIGITS(D), .SCAN_DIV_W(SW), .BLINK_DIV_W(BW), .GUARD_CYC(GC), .ACTIVE_LOW(AL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    img_t m_act, m_pend;
    logic m_pending;
    int   k;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    task automatic model_reset();
        m_act     = '{mode: 1'b0, data: '0, raw: '0, dp: '0, blank: '0, blink: '0};
        m_pend    = m_act;
        m_pending = 1'b0;
        k         = 0;
    endtask

    // One clock edge: predict outputs from the cycle count and the model image, then compare.
    task automatic step();
        logic       en_s, load_s, phase, dark, wrap;
        img_t       in_s;
        int         pos, dig, hi;
        logic [7:0] es, byte_on;
        logic [3:0] ea;
        en_s   = bus.en;
        load_s = bus.load;
        in_s   = '{mode: bus.mode, data: bus.data, raw: bus.raw_seg,
                   dp: bus.dp, blank: bus.blank, blink: bus.blink};
        @(posedge clk);
        k++;
        pos   = (k - 1) % DWELL;
        dig   = ((k - 1) / DWELL) % D;
        phase = ((k - 1) % BLINK) >= (BLINK / 2);
        dark  = m_act.blank[dig] | (m_act.blink[dig] & phase);
`ifdef SEG_LZB_EN
        if (!m_act.mode) begin
            hi = 0;
            for (int i = 0; i < D; i++) if (m_act.data[4*i +: 4] != 4'h0) hi = i;
            if (dig > hi) dark = 1'b1;
        end
`else
        hi = 0;
`endif
        ea = 4'hF;
        es = 8'hFF;
        if (en_s && pos >= GC && !dark) begin
            byte_on = m_act.mode ? m_act.raw[8*dig +: 8] : {m_act.dp[dig], glyph(m_act.data[4*dig +: 4])};
            ea = ~(4'b0001 << dig);
            es = ~byte_on;
        end
        wrap = (k % FRAME) == 0;
        if (wrap && m_pending) m_act = m_pend;
        if (load_s) m_pend = in_s;
        m_pending = load_s | (m_pending & ~wrap);
        #1;
        check("an", 32'(bus.an), 32'(ea));
        check("seg", 32'(bus.seg), 32'(es));
        check("pending", 32'(bus.pending), 32'(m_pending));
        check("frame", 32'(bus.frame), 32'(wrap));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic mode, input logic [15:0] data, input logic [31:0] raw,
                           input logic [3:0] dp, input logic [3:0] blank, input logic [3:0] blink);
        bus.mode = mode; bus.data = data; bus.raw_seg = raw;
        bus.dp = dp; bus.blank = blank; bus.blink = blink;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic run_until(input int target_mod);
        for (int i = 0; i < FRAME && (k % FRAME) != target_mod; i++) step();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_an"}, 32'(bus.an), 32'hF);
        check({tag, "_seg"}, 32'(bus.seg), 32'hFF);
        check({tag, "_pending"}, 32'(bus.pending), 32'h0);
        check({tag, "_frame"}, 32'(bus.frame), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0; bus.mode = 1'b0; bus.data = '0;
        bus.raw_seg = '0; bus.dp = '0; bus.blank = '0; bus.blink = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk) rst = 1'b0;
        model_reset();

        // Basic hex image, then a mid-frame reload that must wait for the wrap.
        bus.en = 1'b1;
        do_load(1'b0, 16'h12AF, 32'h0, 4'b0000, 4'b0000, 4'b0000);
        run(3 * FRAME);
        run_until(30);
        do_load(1'b0, 16'h0003, 32'h0, 4'b0100, 4'b0000, 4'b0000);
        run(FRAME + 20);

        // Blink and blank masks.
        do_load(1'b0, 16'h5E7C, 32'h0, 4'b1001, 4'b1000, 4'b0010);
        run(4 * FRAME);

        // Back-to-back loads: last wins; then a load landing on the wrap edge.
        do_load(1'b0, 16'h1111, 32'h0, 4'b0000, 4'b0000, 4'b0000);
        do_load(1'b0, 16'h9876, 32'h0, 4'b0000, 4'b0000, 4'b0000);
        run_until(FRAME - 1);
        do_load(1'b0, 16'hBEEF, 32'h0, 4'b0011, 4'b0000, 4'b0000);
        run(2 * FRAME);

        // Raw mode, masks still honoured.
        do_load(1'b1, 16'h0000, 32'hC0F9A4B0, 4'b0000, 4'b0000, 4'b0000);
        run(2 * FRAME);
        do_load(1'b1, 16'h0000, 32'h12345678, 4'b0000, 4'b0001, 4'b0100);
        run(2 * FRAME);

        // Display disable keeps the scan running.
        bus.en = 1'b0;
        run(40);
        bus.en = 1'b1;
        run(FRAME);

        // Leading-zero case; shows all digits unless SEG_LZB_EN is defined.
        do_load(1'b0, 16'h0030, 32'h0, 4'b0000, 4'b0000, 4'b0000);
        run(2 * FRAME);
        do_load(1'b0, 16'h0000, 32'h0, 4'b0000, 4'b0000, 4'b0000);
        run(2 * FRAME);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            bus.en      = ($urandom_range(0, 7) != 0);
            bus.load    = ($urandom_range(0, 19) == 0);
            bus.mode    = ($urandom_range(0, 3) == 0);
            bus.data    = 16'($urandom);
            bus.raw_seg = $urandom;
            bus.dp      = 4'($urandom);
            bus.blank   = 4'($urandom) & 4'($urandom);
            bus.blink   = 4'($urandom);
            step();
        end
        bus.load = 1'b0;
        bus.en   = 1'b1;
        run(FRAME);

        // Asynchronous reset while a digit is being driven.
        do_load(1'b0, 16'h4321, 32'h0, 4'b0000, 4'b0000, 4'b0000);
        run_until(0);
        run(DWELL + 8);
        #2 rst = 1'b1;
        #1 check_idle("rst_async");
        @(posedge clk);
        #1 check_idle("rst_hold");
        @(negedge clk) rst = 1'b0;
        model_reset();
        run(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout k=%0d", k);
        $fatal(1, "bench time limit reached");
    end

endmodule
